// File: rtl/uart_bus_sequencer.sv
// Register-bus master for the UART peripheral: turns send requests into data/control
// writes and polls for received bytes. Define SEQ_RX_ECHO_EN to echo RX bytes back out.
module uart_bus_sequencer #(
    parameter int POLL_GAP   = 16,
    parameter int TX_TIMEOUT = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  tx_byte_i,
    input  logic        send_i,
    output logic        busy_o,
    output logic [7:0]  rx_byte_o,
    output logic        rx_valid_o,
    output logic        err_o,
    output logic        wr_o,
    output logic        reg_sel_o,
    output logic        addr_o,
    output logic [31:0] entrada_o,
    input  logic [31:0] salida_i
);
    localparam int TW = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT + 1) : 1;
    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP + 1) : 1;
    localparam logic [TW-1:0] TMR_LAST = TW'(TX_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_DATA = 3'd1;
    localparam logic [2:0] S_WR_CTRL = 3'd2;
    localparam logic [2:0] S_POLL_TX = 3'd3;
    localparam logic [2:0] S_GAP_TX  = 3'd4;
    localparam logic [2:0] S_RD_STAT = 3'd5;
    localparam logic [2:0] S_RD_DATA = 3'd6;
    localparam logic [2:0] S_CLR_RX  = 3'd7;

    logic [2:0]    state_q, state_d;
    logic          pend_q, pend_d;
    logic [7:0]    tx_q, tx_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          rx_valid_q, rx_valid_d;
    logic          err_q, err_d;
    logic [TW-1:0] timer_q, timer_d, timer_inc;
    logic [GW-1:0] gap_q, gap_d;

    logic unused_salida;
    assign unused_salida = ^salida_i[31:8];

    // Timer saturates at the timeout value so a coarse poll grid cannot step over it.
    assign timer_inc = (timer_q == TMR_LAST) ? timer_q : timer_q + TW'(1);

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        tx_d       = tx_q;
        rx_byte_d  = rx_byte_q;
        rx_valid_d = 1'b0;
        err_d      = err_q;
        timer_d    = timer_q;
        gap_d      = gap_q;
        wr_o       = 1'b0;
        reg_sel_o  = 1'b0;
        addr_o     = 1'b0;
        entrada_o  = 32'h0;
        case (state_q)
            S_IDLE: begin
                if (pend_q || send_i) begin
                    state_d = S_WR_DATA;
                    pend_d  = 1'b0;
                    if (send_i) tx_d = tx_byte_i;
                end else if (gap_q == GAP_LAST) begin
                    state_d = S_RD_STAT;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            S_WR_DATA: begin
                wr_o      = 1'b1;
                reg_sel_o = 1'b1;
                entrada_o = {24'h0, tx_q};
                state_d   = S_WR_CTRL;
            end
            S_WR_CTRL: begin
                wr_o      = 1'b1;
                entrada_o = 32'h1;
                timer_d   = '0;
                state_d   = S_POLL_TX;
            end
            S_POLL_TX: begin
                timer_d = timer_inc;
                if (!salida_i[0]) begin
                    state_d = S_IDLE;
                    gap_d   = '0;
                end else if (timer_q == TMR_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                    gap_d   = '0;
                end else begin
                    state_d = S_GAP_TX;
                    gap_d   = '0;
                end
            end
            S_GAP_TX: begin
                timer_d = timer_inc;
                if (gap_q == GAP_LAST) state_d = S_POLL_TX;
                else                   gap_d   = gap_q + GW'(1);
            end
            S_RD_STAT: begin
                if (salida_i[1]) begin
                    state_d = S_RD_DATA;
                end else begin
                    state_d = S_IDLE;
                    gap_d   = '0;
                end
            end
            S_RD_DATA: begin
                reg_sel_o  = 1'b1;
                addr_o     = 1'b1;
                rx_byte_d  = salida_i[7:0];
                rx_valid_d = 1'b1;
                state_d    = S_CLR_RX;
            end
            default: begin
                wr_o    = 1'b1;
                state_d = S_IDLE;
                gap_d   = '0;
`ifdef SEQ_RX_ECHO_EN
                if (!pend_q && !send_i) begin
                    pend_d = 1'b1;
                    tx_d   = rx_byte_q;
                end
`endif
            end
        endcase
        // Requests outside IDLE park in the one-deep pending slot; the newest byte wins.
        if (send_i && state_q != S_IDLE) begin
            pend_d = 1'b1;
            tx_d   = tx_byte_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            pend_q     <= 1'b0;
            tx_q       <= 8'h0;
            rx_byte_q  <= 8'h0;
            rx_valid_q <= 1'b0;
            err_q      <= 1'b0;
            timer_q    <= '0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            tx_q       <= tx_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
            err_q      <= err_d;
            timer_q    <= timer_d;
            gap_q      <= gap_d;
        end
    end

    assign busy_o     = pend_q || !(state_q == S_IDLE || state_q == S_RD_STAT ||
                                    state_q == S_RD_DATA || state_q == S_CLR_RX);
    assign rx_byte_o  = rx_byte_q;
    assign rx_valid_o = rx_valid_q;
    assign err_o      = err_q;
endmodule

// File: tb/tb_uart_bus_sequencer.sv
// Randomized bench for uart_bus_sequencer with a behavioural UART register-port model
// and an expected-frame scoreboard.
module tb_uart_bus_sequencer;
    localparam int POLL_GAP   = 16;
    localparam int TX_TIMEOUT = 300;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  tx_byte_i = 8'h0;
    logic        send_i = 1'b0;
    logic        busy_o, rx_valid_o, err_o, wr_o, reg_sel_o, addr_o;
    logic [7:0]  rx_byte_o;
    logic [31:0] entrada_o, salida_i;

    uart_bus_sequencer #(.POLL_GAP(POLL_GAP), .TX_TIMEOUT(TX_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .tx_byte_i(tx_byte_i), .send_i(send_i),
        .busy_o(busy_o), .rx_byte_o(rx_byte_o), .rx_valid_o(rx_valid_o),
        .err_o(err_o), .wr_o(wr_o), .reg_sel_o(reg_sel_o), .addr_o(addr_o),
        .entrada_o(entrada_o), .salida_i(salida_i)
    );

    always #5 clk = ~clk;

    // Peripheral model: control, TX data and RX data registers.
    logic [31:0] ctrl, txd, rxd;
    int          bit0_cnt;
    int          tx_delay = 20;  // 0 = never complete the frame
    int          rx_req_cnt = 0, rx_done_cnt = 0;
    logic [7:0]  rx_req_byte = 8'h0;
    logic [7:0]  act_frames[$];
    logic [7:0]  exp_frames[$];
    int          errors = 0, checks = 0;

    assign salida_i = reg_sel_o ? (addr_o ? rxd : txd) : ctrl;

    always @(posedge clk) begin
        if (!rst) begin
            ctrl <= 32'h0; txd <= 32'h0; rxd <= 32'h0; bit0_cnt <= 0;
        end else begin
            if (rx_req_cnt != rx_done_cnt) begin
                rxd         <= {24'h0, rx_req_byte};
                ctrl[1]     <= 1'b1;
                rx_done_cnt <= rx_done_cnt + 1;
            end
            if (ctrl[0] && tx_delay != 0) begin
                if (bit0_cnt <= 1) ctrl[0] <= 1'b0;
                else               bit0_cnt <= bit0_cnt - 1;
            end
            if (wr_o && reg_sel_o && !addr_o) txd <= entrada_o;
            if (wr_o && !reg_sel_o) begin
                ctrl     <= entrada_o;
                bit0_cnt <= tx_delay;
                if (entrada_o[0]) act_frames.push_back(txd[7:0]);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_frames(input string tag);
        chk({tag, "_count"}, act_frames.size(), exp_frames.size());
        for (int i = 0; i < exp_frames.size() && i < act_frames.size(); i++)
            chk(tag, act_frames[i], exp_frames[i]);
        act_frames.delete();
        exp_frames.delete();
    endtask

    task automatic send(input logic [7:0] b);
        tx_byte_i = b;
        send_i    = 1'b1;
        @(negedge clk);
        send_i    = 1'b0;
    endtask

    task automatic inject_rx(input logic [7:0] b);
        rx_req_byte = b;
        rx_req_cnt++;
    endtask

    task automatic settle();
        int n;
        repeat (3) @(negedge clk);
        n = 0;
        while (busy_o && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("settle_busy", busy_o, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_rx(input string tag, output int n);
        n = 0;
        while (!rx_valid_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_seen"}, rx_valid_o, 1'b1);
    endtask

    task automatic wait_ctrl_go(output int n);
        n = 0;
        while (!(wr_o && !reg_sel_o && entrada_o[0]) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ctrl_go_seen", wr_o && !reg_sel_o && entrada_o[0], 1'b1);
    endtask

    initial begin
        int n;
        logic [7:0] b, last;
        int k;

        repeat (3) @(negedge clk);
        chk("rst_wr", wr_o, 0);
        chk("rst_reg_sel", reg_sel_o, 0);
        chk("rst_addr", addr_o, 0);
        chk("rst_entrada", entrada_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_rx_valid", rx_valid_o, 0);
        chk("rst_rx_byte", rx_byte_o, 0);
        chk("rst_err", err_o, 0);

        // First status poll comes POLL_GAP idle cycles after reset release.
        rst = 1'b1;
        inject_rx(8'h3C);
        wait_rx("rx_first", n);
        chk("rx_first_latency", (n >= POLL_GAP + 1) && (n <= POLL_GAP + 3), 1'b1);
        chk("rx_first_byte", rx_byte_o, 8'h3C);
        @(negedge clk);
        chk("rx_pulse_width", rx_valid_o, 0);
        chk("rx_hold", rx_byte_o, 8'h3C);
`ifdef SEQ_RX_ECHO_EN
        exp_frames.push_back(8'h3C);
`endif
        settle();
        chk("rx_ctrl_cleared", ctrl[1], 0);
        chk_frames("rx_first_echo");

        // Single transmit with a slow peripheral.
        tx_delay = 200;
        send(8'hA5);
        n = 0;
        while (!(wr_o && reg_sel_o) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("tx_data_wr", wr_o, 1);
        chk("tx_data_addr", addr_o, 0);
        chk("tx_data_val", entrada_o, 32'hA5);
        @(negedge clk);
        chk("tx_ctrl_wr", wr_o, 1);
        chk("tx_ctrl_sel", reg_sel_o, 0);
        chk("tx_ctrl_val", entrada_o, 32'h1);
        @(negedge clk);
        chk("tx_one_write", wr_o, 0);
        chk("tx_busy", busy_o, 1);
        n = 1;
        while (busy_o && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("tx_busy_fall_window", (n >= tx_delay + 1) && (n <= tx_delay + POLL_GAP + 3), 1'b1);
        exp_frames.push_back(8'hA5);
        settle();
        chk_frames("tx_a5");
        chk("tx_no_err", err_o, 0);

        // Random single transmits.
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            tx_delay = $urandom_range(1, 80);
            repeat ($urandom_range(0, 20)) @(negedge clk);
            send(b);
            exp_frames.push_back(b);
            settle();
            chk_frames("tx_rand");
        end

        // Requests while busy: one pending slot, last byte wins.
        tx_delay = 60;
        send(8'h11);
        repeat (3) @(negedge clk);
        send(8'h22);
        repeat (2) @(negedge clk);
        send(8'h33);
        exp_frames.push_back(8'h11);
        exp_frames.push_back(8'h33);
        settle();
        chk_frames("b2b_fixed");
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            send(b);
            exp_frames.push_back(b);
            k = $urandom_range(1, 4);
            last = 8'h0;
            for (int j = 0; j < k; j++) begin
                repeat ($urandom_range(1, 4)) @(negedge clk);
                last = 8'($urandom);
                send(last);
            end
            exp_frames.push_back(last);
            settle();
            chk_frames("b2b_rand");
        end

        // Random receives.
        tx_delay = 10;
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            inject_rx(b);
            wait_rx("rx_rand", n);
            chk("rx_rand_byte", rx_byte_o, b);
            @(negedge clk);
            chk("rx_rand_pulse", rx_valid_o, 0);
`ifdef SEQ_RX_ECHO_EN
            exp_frames.push_back(b);
`endif
            settle();
            chk("rx_rand_clr", ctrl[1], 0);
            chk_frames("rx_rand_echo");
        end

        // Peripheral never finishes: sticky error after TX_TIMEOUT cycles.
        chk("pre_to_err", err_o, 0);
        tx_delay = 0;
        send(8'hC3);
        wait_ctrl_go(n);
        n = 0;
        while (!err_o && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("to_err_set", err_o, 1);
        chk("to_window", (n >= TX_TIMEOUT) && (n <= TX_TIMEOUT + POLL_GAP + 4), 1'b1);
        settle();
        repeat (50) @(negedge clk);
        chk("to_err_sticky", err_o, 1);
        chk("to_idle", busy_o, 0);
        exp_frames.push_back(8'hC3);
        chk_frames("to_frame");

        rst = 1'b0;
        @(negedge clk);
        chk("rst2_err", err_o, 0);
        chk("rst2_busy", busy_o, 0);
        chk("rst2_wr", wr_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
